// File: rtl/mbm_seq_ctrl_pkg.sv
// ============================================================================
// Module   : mbm_seq_ctrl_pkg
// Purpose  : Shared constants and state encoding for the MBM sequential controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mbm_seq_ctrl_pkg;

  localparam int c_N      = 8;
  localparam int c_L      = 3;
  localparam int c_FRAC_W = c_N - 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOD_A = 3'd1,
    S_LOD_B = 3'd2,
    S_CALC  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mbm_seq_ctrl_lod.sv
// ============================================================================
// Module   : mbm_seq_ctrl_lod
// Purpose  : 8-bit leading-one detector; both 0 and 1 map to position 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mbm_seq_ctrl_lod
  import mbm_seq_ctrl_pkg::*;
(
  input  logic [c_N-1:0] i_d,
  output logic [c_L-1:0] o_k
);

  // Ascending scan: the highest set bit wins.
  always_comb begin
    o_k = '0;
    for (int i = 0; i < c_N; i++) begin
      if (i_d[i]) begin
        o_k = c_L'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mbm_seq_ctrl.sv
// ============================================================================
// Module   : mbm_seq_ctrl
// Purpose  : Mitchell multiplier controller sharing one LOD across both operands.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mbm_seq_ctrl
  import mbm_seq_ctrl_pkg::*;
#(
  parameter int N = c_N,
  parameter int L = c_L
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_in_valid,
  output logic           o_in_ready,
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic           o_out_valid,
  input  logic           i_out_ready,
  output logic [2*N-1:0] o_p,
  output logic           o_busy
);

  state_t           r_state;
  state_t           w_next;

  logic [N-1:0]     r_a;
  logic [N-1:0]     r_b;
  logic             r_z;
  logic [L-1:0]     r_k1;
  logic [L-1:0]     r_k2;
  logic [N-2:0]     r_x1;
  logic [N-2:0]     r_x2;
  logic [2*N-1:0]   r_p;

  logic [N-1:0]     w_lod_in;
  logic [L-1:0]     w_k;
  logic [N-2:0]     w_x;
  logic [N-1:0]     w_s;
  logic             w_c;
  logic [L:0]       w_e;
  logic [N-1:0]     w_m;
  logic [2*N-1:0]   w_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_in_valid) w_next = S_LOD_A;
      S_LOD_A: w_next = S_LOD_B;
      S_LOD_B: w_next = S_CALC;
      S_CALC:  w_next = S_DONE;
      S_DONE:  if (i_out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_in_ready  = (r_state == S_IDLE);
    o_out_valid = (r_state == S_DONE);
    o_busy      = (r_state != S_IDLE);
  end

  assign o_p = r_p;

  assign w_lod_in = (r_state == S_LOD_A) ? r_a : r_b;

  mbm_seq_ctrl_lod u_lod (
    .i_d (w_lod_in),
    .o_k (w_k)
  );

  // Strip the leading one and left-align the remainder as an (N-1)-bit fraction.
  assign w_x = (N-1)'((w_lod_in & ~(N'(1) << w_k)) << (L'(N - 1) - w_k));

  assign w_s = {1'b0, r_x1} + {1'b0, r_x2};
  assign w_c = w_s[N-1];
  assign w_e = (L+1)'(r_k1) + (L+1)'(r_k2) + (L+1)'(w_c);
  assign w_m = {1'b1, w_s[N-2:0]};
  assign w_p = (2*N)'(((3*N-1)'(w_m) << w_e) >> (N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a  <= '0;
      r_b  <= '0;
      r_z  <= 1'b0;
      r_k1 <= '0;
      r_k2 <= '0;
      r_x1 <= '0;
      r_x2 <= '0;
      r_p  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_a <= i_a;
            r_b <= i_b;
            r_z <= (i_a == '0) | (i_b == '0);
          end
        end
        S_LOD_A: begin
          r_k1 <= w_k;
          r_x1 <= w_x;
        end
        S_LOD_B: begin
          r_k2 <= w_k;
          r_x2 <= w_x;
        end
        S_CALC: begin
          r_p <= r_z ? '0 : w_p;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
